sram_bus_arbiter: RTL and testbench
===================================

# sram_bus_arbiter

Sits directly downstream of the CPU core. It merges the core's instruction-side and data-side SRAM-like request ports onto one shared memory bus, with exactly one transaction outstanding at a time. Data requests take priority over instruction requests, and a starvation counter bounds how long instruction fetch can be locked out. Read data and completion are returned through a registered response stage.

## Interface
Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- STARVE_LIMIT, 4, consecutive data grants allowed while an inst request waits; must be 1..15

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- inst_req  in  1  instruction request; held with its fields until inst_addr_ok
- inst_wen  in  4  byte write strobes; 0 means read
- inst_addr  in  ADDR_W  request address
- inst_wdata  in  DATA_W  write data
- inst_addr_ok  out  1  request accepted by the bus
- inst_data_ok  out  1  one-cycle completion pulse
- inst_rdata  out  DATA_W  read data, valid only while inst_data_ok is high
- data_req, data_wen, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata: same directions, widths and meanings as the inst_* ports, for the data side
- bus_req  out  1  request to memory
- bus_wstrb  out  4  byte strobes of the granted request
- bus_addr  out  ADDR_W  address of the granted request
- bus_wdata  out  DATA_W  write data of the granted request
- bus_addr_ok  in  1  memory accepts the request
- bus_data_ok  in  1  memory completes the transaction; acknowledges writes as well as reads
- bus_rdata  in  DATA_W  read data, valid with bus_data_ok

## Operation
- State machine IDLE / ADDR / DATA / RESP, plus an owner register (INST or DATA).
- IDLE:
  - If any request is asserted, pick the owner and go to ADDR.
  - Selection: data wins, unless inst_req is high and starve_cnt == STARVE_LIMIT, in which case inst wins.
- ADDR:
  - bus_req = 1. bus_wstrb, bus_addr and bus_wdata are driven combinationally from the owner's inputs; masters hold these stable.
  - On bus_addr_ok, assert the owner's *_addr_ok in the same cycle (combinational pass-through) and go to DATA.
  - A non-owner never sees addr_ok.
- DATA:
  - bus_req = 0. Wait for bus_data_ok.
  - On bus_data_ok, capture bus_rdata into resp_data and go to RESP.
- RESP:
  - Drive the owner's *_data_ok = 1 and its *_rdata = resp_data for exactly one cycle, then go to IDLE.
- Non-owner rdata outputs are 0.
- starve_cnt (4 bits):
  - Increments at each data grant made while inst_req is high, saturating at STARVE_LIMIT.
  - Clears to 0 on any inst grant, or at a data grant made while inst_req is low.
- Ignored inputs:
  - bus_addr_ok outside ADDR is ignored.
  - bus_data_ok outside DATA is ignored. It is not buffered and raises no error.
- Both requests deasserted in IDLE: stay in IDLE with all outputs 0.
- A master that drops req before addr_ok violates protocol. Behaviour is undefined, but the FSM must not lock up: in ADDR it keeps waiting for bus_addr_ok.

## Timing
- Reset (async, immediate):
  - state = IDLE, owner = DATA, starve_cnt = 0, resp_data = 0.
  - All outputs 0: bus_req, bus_wstrb, bus_addr, bus_wdata, all *_addr_ok, *_data_ok and *_rdata.
- Reset during ADDR, DATA or RESP aborts the transaction. No data_ok is ever produced for it.
- Minimum latency: req seen in IDLE at cycle 0 → bus_req at cycle 1 (bus_addr_ok same cycle) → bus_data_ok at cycle 2 → owner data_ok at cycle 3.
- Back-to-back: the next grant is decided in the IDLE cycle after RESP. Minimum spacing between bus_req assertions is 4 cycles.
- Arbitration is sampled only in IDLE. Requests arriving during ADDR, DATA or RESP wait.
- bus_req stays high through any number of bus_addr_ok wait cycles. Bus fields must not change while bus_req is high.

## Test plan
- Single read: data_req=1, data_wen=0, data_addr=0x1000. Bus gives addr_ok at cycle 1 and data_ok with rdata 0xDEADBEEF at cycle 2 → data_addr_ok at cycle 1; data_data_ok=1 and data_rdata=0xDEADBEEF at cycle 3 only; inst outputs stay 0.
- Write with wait states: inst_req=1, inst_wen=4'b0011, addr 0x20, wdata 0x1234. addr_ok is delayed 3 cycles → bus_req is held for 4 cycles with bus_wstrb=0011 and bus_wdata=0x1234; inst_data_ok pulses once, one cycle after bus_data_ok.
- Priority: inst_req and data_req both rise in the same cycle with STARVE_LIMIT=4 → data granted first; inst is granted on the second transaction, after data_req drops.
- Starvation: data_req held continuously and inst_req held continuously → grant order D,D,D,D,I,D,D,D,D,I…; starve_cnt reads 4 at each inst grant and 0 after it.
- Reset mid-transaction: assert rst while in DATA → all outputs 0 in the same cycle. A bus_data_ok arriving after reset is released is ignored, and no data_ok pulse is produced.
- Spurious bus signals: bus_data_ok or bus_addr_ok pulsed while in IDLE → no state change and no master-side pulses.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// Merges the core's instruction and data SRAM-like ports onto one memory bus,
// one transaction at a time, data first with a starvation bound on fetch.
module sram_bus_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              inst_req,
  input  logic [3:0]        inst_wen,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  output logic              bus_req,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e            state_q, state_d;
  logic              owner_inst_q, owner_inst_d;
  logic [3:0]        starve_q, starve_d;
  logic [DATA_W-1:0] resp_q, resp_d;
  logic              grant_inst;

  // Fetch only overrides data once it has been passed over STARVE_LIMIT times in a row.
  assign grant_inst = inst_req && (!data_req || (starve_q == Limit));

  always_comb begin
    state_d      = state_q;
    owner_inst_d = owner_inst_q;
    starve_d     = starve_q;
    resp_d       = resp_q;
    bus_req      = 1'b0;
    bus_wstrb    = '0;
    bus_addr     = '0;
    bus_wdata    = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;

    case (state_q)
      StIdle: begin
        if (inst_req || data_req) begin
          state_d      = StAddr;
          owner_inst_d = grant_inst;
          if (grant_inst || !inst_req) begin
            starve_d = '0;
          end else if (starve_q < Limit) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      StAddr: begin
        bus_req = 1'b1;
        if (owner_inst_q) begin
          bus_wstrb = inst_wen;
          bus_addr  = inst_addr;
          bus_wdata = inst_wdata;
        end else begin
          bus_wstrb = data_wen;
          bus_addr  = data_addr;
          bus_wdata = data_wdata;
        end
        if (bus_addr_ok) begin
          state_d      = StData;
          inst_addr_ok = owner_inst_q;
          data_addr_ok = !owner_inst_q;
        end
      end
      StData: begin
        if (bus_data_ok) begin
          resp_d  = bus_rdata;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
        if (owner_inst_q) begin
          inst_data_ok = 1'b1;
          inst_rdata   = resp_q;
        end else begin
          data_data_ok = 1'b1;
          data_rdata   = resp_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_inst_q <= 1'b0;
      starve_q     <= '0;
      resp_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_inst_q <= owner_inst_d;
      starve_q     <= starve_d;
      resp_q       <= resp_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed protocol steps followed by random traffic
// checked against a transaction-level arbitration model.
module tb_sram_bus_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req;
  logic [3:0]  inst_wen, data_wen;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_addr_ok, bus_data_ok;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int checks = 0;
  int failures = 0;
  int streak = 0;  // data grants made in a row while fetch was waiting
  bit gi;
  bit exp_order [0:9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  always #5 clk = ~clk;

  sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wen(inst_wen), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {bus_req, bus_wstrb, inst_addr_ok, inst_data_ok, data_addr_ok,
                        data_data_ok}, '0);
    chk({tag, "_vec"}, bus_addr | bus_wdata | inst_rdata | data_rdata, '0);
  endtask

  // Runs one full transaction starting in an idle cycle whose requests are already driven.
  task automatic do_txn(input int aw, input int dw, input logic [31:0] rd, output bit g);
    logic [3:0]  es;
    logic [31:0] ea, ed;
    g = inst_req && (!data_req || streak == LIMIT);
    if (g || !inst_req) streak = 0;
    else streak = (streak < LIMIT) ? streak + 1 : LIMIT;
    es = g ? inst_wen : data_wen;
    ea = g ? inst_addr : data_addr;
    ed = g ? inst_wdata : data_wdata;
    tick();
    bus_addr_ok = 1'b0;
    for (int i = 0; i < aw; i++) begin
      bus_data_ok = 1'($urandom_range(0, 1));
      #1;
      chk("addr_wait_req", bus_req, 1);
      chk("addr_wait_fields", {bus_wstrb, bus_addr, bus_wdata}, {es, ea, ed});
      chk("addr_wait_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
      tick();
    end
    bus_data_ok = 1'b0;
    bus_addr_ok = 1'b1;
    #1;
    chk("grant_req_fields", {bus_req, bus_wstrb, bus_addr, bus_wdata}, {1'b1, es, ea, ed});
    chk("grant_addr_ok", {inst_addr_ok, data_addr_ok}, g ? 2'b10 : 2'b01);
    tick();
    bus_addr_ok = 1'b0;
    if (g) inst_req = 1'b0;
    else data_req = 1'b0;
    for (int i = 0; i < dw; i++) begin
      bus_addr_ok = 1'($urandom_range(0, 1));
      #1;
      chk("data_wait", {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
      tick();
    end
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = rd;
    #1;
    chk("data_done", {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
    tick();
    bus_data_ok = 1'($urandom_range(0, 1));
    bus_addr_ok = 1'($urandom_range(0, 1));
    bus_rdata   = $urandom;
    #1;
    chk("resp_ok", {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok},
        g ? 5'b00010 : 5'b00001);
    chk("resp_rdata", {inst_rdata, data_rdata}, g ? {rd, 32'h0} : {32'h0, rd});
    tick();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    #1;
    chk_quiet("idle_after");
  endtask

  initial begin
    rst = 1'b1;
    {inst_req, inst_wen, inst_addr, inst_wdata} = '0;
    {data_req, data_wen, data_addr, data_wdata} = '0;
    {bus_addr_ok, bus_data_ok, bus_rdata} = '0;
    #1;
    chk_quiet("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_quiet("idle_no_req");

    // Single read with minimum latency
    data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h1000;
    do_txn(0, 0, 32'hDEADBEEF, gi);
    chk("single_read_owner", gi, 0);

    // Write with three addr_ok wait states
    inst_req = 1'b1; inst_wen = 4'b0011; inst_addr = 32'h20; inst_wdata = 32'h1234;
    do_txn(3, 0, 32'h0, gi);
    chk("write_owner", gi, 1);

    // Simultaneous requests: data first, fetch second
    inst_req = 1'b1; inst_addr = 32'h44; inst_wen = 4'h0;
    data_req = 1'b1; data_addr = 32'h88; data_wen = 4'hF; data_wdata = 32'hCAFE0001;
    do_txn(1, 1, 32'h55AA55AA, gi);
    chk("prio_first", gi, 0);
    do_txn(0, 2, 32'h11112222, gi);
    chk("prio_second", gi, 1);

    // Both held continuously: four data grants, then one fetch
    for (int n = 0; n < 10; n++) begin
      inst_req = 1'b1; inst_addr = 32'h100 + 32'(n);
      data_req = 1'b1; data_addr = 32'h200 + 32'(n);
      do_txn(n % 2, n % 3, $urandom, gi);
      chk("starve_order", gi, exp_order[n]);
    end
    inst_req = 1'b0;
    data_req = 1'b0;

    // Reset while in DATA
    data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h40;
    tick();
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    data_req = 1'b0;
    #1;
    chk("pre_reset_data", {bus_req, data_addr_ok, data_data_ok}, 0);
    rst = 1'b1;
    #1;
    chk_quiet("reset_mid");
    tick();
    rst = 1'b0;
    streak = 0;
    bus_data_ok = 1'b1;
    bus_rdata = 32'hBAD0BAD0;
    #1;
    chk_quiet("post_reset_dok");
    tick();
    bus_data_ok = 1'b0;
    #1;
    chk_quiet("post_reset_1");
    tick();
    chk_quiet("post_reset_2");

    // Spurious bus handshakes in IDLE
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    #1;
    chk_quiet("spurious_0");
    tick();
    chk_quiet("spurious_1");
    tick();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    inst_req = 1'b1; inst_wen = 4'h0; inst_addr = 32'h300;
    do_txn(0, 0, 32'h0BADF00D, gi);
    chk("after_spurious_owner", gi, 1);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      if (!inst_req) begin
        inst_req   = 1'($urandom_range(0, 1));
        inst_wen   = 4'($urandom_range(0, 15));
        inst_addr  = $urandom;
        inst_wdata = $urandom;
      end
      if (!data_req) begin
        data_req   = 1'($urandom_range(0, 1));
        data_wen   = 4'($urandom_range(0, 15));
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      if (!inst_req && !data_req) begin
        bus_addr_ok = 1'($urandom_range(0, 1));
        bus_data_ok = 1'($urandom_range(0, 1));
        #1;
        chk_quiet("rand_idle");
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        data_req = 1'b1;
      end
      do_txn($urandom_range(0, 3), $urandom_range(0, 2), $urandom, gi);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
